// File: rtl/hrm_pkg.sv
// Shared definitions for the HRM core: sequencer state encoding and the
// opcode values the sequencer, control unit and datapath must agree on.
package hrm_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } seq_state_t;

  localparam logic [3:0] OP_INBOX  = 4'h1;
  localparam logic [3:0] OP_OUTBOX = 4'h2;
  localparam logic [3:0] OP_JUMP   = 4'h8;
  localparam logic [3:0] OP_JUMPZ  = 4'h9;
  localparam logic [3:0] OP_JUMPN  = 4'hA;
  localparam logic [3:0] OP_HALT   = 4'hF;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter: parallel load has priority over increment; the
// increment wraps naturally at 2^W.
module pc_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  // PC register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= din;
    else if (inc)  q <= q + W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/execute sequencer for the HRM core.
// Optional build macro FETCH_SEQUENCER_SINGLE_STEP_EN adds a 'step' input
// that gates each instruction's execute phase (one pulse = one instruction).
//
//   state  | meaning
//   FETCH  | present pc on pmem_addr
//   DECODE | ROM data valid, latch IR
//   EXEC   | run handshakes, strobe exec_en, update pc
//   HALT   | stopped until reset
module fetch_sequencer
  import hrm_pkg::*;
#(
  parameter int PMEM_AW = 8
) (
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic               clk,
  input  logic               rst_n,
  output logic [PMEM_AW-1:0] pmem_addr,
  input  logic [11:0]        pmem_data,
  output logic [3:0]         opcode,
  output logic [7:0]         operand,
  input  logic               branch,
  input  logic               ijump,
  input  logic               rIn,
  input  logic               wO,
  input  logic               flag_z,
  input  logic               flag_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               exec_en,
  output logic               halted,
  output logic [PMEM_AW-1:0] pc
);

  seq_state_t state, state_nx;
  logic       in_done;
  logic       in_done_set;
  logic       ir_load;
  logic       go;
  logic       taken;
  logic       is_halt;

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  logic step_seen;
  assign go = step | step_seen;
`else
  assign go = 1'b1;
`endif

  assign is_halt   = (opcode == OP_HALT);
  assign taken     = ijump
                   | (branch & (opcode == OP_JUMPZ) & flag_z)
                   | (branch & (opcode == OP_JUMPN) & flag_n);
  assign pmem_addr = pc;
  assign halted    = (state == ST_HALT);

  pc_reg #(.W(PMEM_AW)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (exec_en & taken & ~is_halt),
    .inc   (exec_en & ~taken & ~is_halt),
    .din   (PMEM_AW'(operand)),
    .q     (pc)
  );

  // State, instruction register and illegal-decode inbox bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      opcode  <= '0;
      operand <= '0;
      in_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (ir_load) begin
        opcode  <= pmem_data[11:8];
        operand <= pmem_data[7:0];
      end
      if (state_nx != ST_EXEC) in_done <= 1'b0;
      else if (in_done_set)    in_done <= 1'b1;
    end
  end

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  // Remember a step pulse for the rest of the current EXEC phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 step_seen <= 1'b0;
    else if (state_nx != ST_EXEC)               step_seen <= 1'b0;
    else if ((state == ST_EXEC) && step)        step_seen <= 1'b1;
  end
`endif

  // Next-state and handshake/strobe decode; an rIn+wO word serves the
  // inbox first and only strobes exec_en on the outbox transfer
  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    exec_en     = 1'b0;
    in_done_set = 1'b0;
    ir_load     = 1'b0;
    case (state)
      ST_FETCH:  state_nx = ST_DECODE;
      ST_DECODE: begin
        ir_load  = 1'b1;
        state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        if (rIn && !in_done) begin
          in_ready = go;
          if (go && in_valid) begin
            if (wO) in_done_set = 1'b1;
            else    exec_en     = 1'b1;
          end
        end else if (wO) begin
          out_valid = go;
          exec_en   = go & out_ready;
        end else begin
          exec_en = go;
        end
        if (exec_en) state_nx = is_halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: synchronous ROM model, a control-unit decode,
// an instruction-level reference model checked every cycle, and directed
// programs whose timing is pinned with literal expectations.
module tb_fetch_sequencer;
  import hrm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pmem_addr;
  logic [11:0] pmem_data = '0;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic        branch, ijump, rIn, wO;
  logic        flag_z = 1'b0, flag_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        out_ready = 1'b0, out_valid;
  logic        exec_en, halted;
  logic [7:0]  pc;

  int checks = 0;
  int errors = 0;

  logic [11:0] rom [256];
  int          cyc = 0;

  // stimulus mode: random handshakes/flags, or fixed values from a cycle on
  bit rnd_mode = 1'b0;
  int iv_on = 0, or_on = 0;
  bit fz_fix = 1'b0, fn_fix = 1'b0;

  // per-cycle logs of DUT outputs (cycle 1 = first cycle after reset release)
  logic [7:0] log_pc   [256];
  logic [7:0] log_addr [256];
  bit         log_ex   [256];
  bit         log_inr  [256];
  bit         log_halt [256];

  always #5 clk = ~clk;

  fetch_sequencer #(.PMEM_AW(8)) dut (
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    .step      (1'b1),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .pmem_addr (pmem_addr),
    .pmem_data (pmem_data),
    .opcode    (opcode),
    .operand   (operand),
    .branch    (branch),
    .ijump     (ijump),
    .rIn       (rIn),
    .wO        (wO),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .exec_en   (exec_en),
    .halted    (halted),
    .pc        (pc)
  );

  always @(posedge clk) pmem_data <= rom[pmem_addr];

  // control-unit decode: 1 inbox, 2 outbox, 3 both (illegal), 8/9/A jumps
  always_comb begin
    rIn = 1'b0; wO = 1'b0; branch = 1'b0; ijump = 1'b0;
    case (opcode)
      OP_INBOX:          rIn = 1'b1;
      OP_OUTBOX:         wO  = 1'b1;
      4'h3:              begin rIn = 1'b1; wO = 1'b1; end
      OP_JUMP:           ijump = 1'b1;
      OP_JUMPZ, OP_JUMPN: branch = 1'b1;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // input driver: values for the upcoming cycle, applied just after posedge
  initial begin
    int n;
    forever begin
      @(posedge clk);
      #1;
      n = cyc + 1;
      if (rnd_mode) begin
        in_valid  = ($urandom_range(0, 3) == 0);
        out_ready = ($urandom_range(0, 2) == 0);
        flag_z    = $urandom_range(0, 1) == 1;
        flag_n    = $urandom_range(0, 1) == 1;
      end else begin
        in_valid  = (n >= iv_on);
        out_ready = (n >= or_on);
        flag_z    = fz_fix;
        flag_n    = fn_fix;
      end
    end
  end

  // reference model: instruction-level view (phase within instruction,
  // architectural pc, IR contents, inbox-already-served for rIn+wO words)
  initial begin
    logic [7:0] m_pc;
    logic [3:0] m_op;
    logic [7:0] m_opd;
    int         m_ph;
    bit         m_in_got, m_halt;
    bit         ri, wo, need_in, e_ex, e_ir, e_ov, tk;
    m_pc = 0; m_op = 0; m_opd = 0; m_ph = 0; m_in_got = 0; m_halt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pc = 0; m_op = 0; m_opd = 0; m_ph = 0; m_in_got = 0; m_halt = 0;
        cyc = 0;
        for (int i = 0; i < 256; i++) begin
          log_pc[i] = 0; log_addr[i] = 0; log_ex[i] = 0; log_inr[i] = 0; log_halt[i] = 0;
        end
      end else begin
        cyc++;
        if (cyc < 256) begin
          log_pc[cyc] = pc; log_addr[cyc] = pmem_addr; log_ex[cyc] = exec_en;
          log_inr[cyc] = in_ready; log_halt[cyc] = halted;
        end
        ri = (m_op == OP_INBOX) || (m_op == 4'h3);
        wo = (m_op == OP_OUTBOX) || (m_op == 4'h3);
        e_ex = 0; e_ir = 0; e_ov = 0;
        if (!m_halt && m_ph >= 2) begin
          need_in = ri && !m_in_got;
          e_ir = need_in;
          e_ov = wo && !need_in;
          e_ex = (!ri && !wo) || (ri && !wo && in_valid) || (e_ov && out_ready);
        end
        chk("pc", pc, m_pc);
        chk("halted", halted, m_halt);
        chk("exec_en", exec_en, e_ex);
        chk("in_ready", in_ready, e_ir);
        chk("out_valid", out_valid, e_ov);
        chk("ir", {opcode, operand}, {m_op, m_opd});
        if (!m_halt && m_ph == 0) chk("pmem_addr", pmem_addr, m_pc);
        if (!m_halt) begin
          if (m_ph == 0) m_ph = 1;
          else if (m_ph == 1) begin
            {m_op, m_opd} = rom[m_pc];
            m_ph = 2;
          end else begin
            if (ri && wo && !m_in_got && in_valid) m_in_got = 1;
            if (e_ex) begin
              if (m_op == OP_HALT) m_halt = 1;
              else begin
                tk = (m_op == OP_JUMP) || (m_op == OP_JUMPZ && flag_z) ||
                     (m_op == OP_JUMPN && flag_n);
                m_pc = tk ? m_opd : m_pc + 8'd1;
              end
              m_ph = 0;
              m_in_got = 0;
            end
          end
        end
      end
    end
  end

  task automatic fill_plain();
    for (int i = 0; i < 256; i++) rom[i] = {4'h4, i[7:0]};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_ir", {opcode, operand}, 12'h000);
    chk("rst_strobes", {exec_en, in_ready, out_valid, halted}, 4'b0000);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 2 * n + 10) begin
      @(posedge clk);
      guard++;
    end
    if (cyc < n) begin
      errors++;
      $display("FAIL run_to: reached cycle %0d expected %0d", cyc, n);
    end
  endtask

  initial begin
    int cnt;
    logic [3:0] op;

    // straight-line program: exec_en at 3,6,9,12; pc 0..4
    fill_plain(); iv_on = 0; or_on = 0;
    do_reset(); run_to(13);
    cnt = 0;
    for (int i = 1; i <= 13; i++) cnt += log_ex[i];
    chk("s1_ex_count", cnt, 4);
    chk("s1_ex_pattern", {log_ex[3], log_ex[6], log_ex[9], log_ex[12]}, 4'hF);
    chk("s1_pc_seq", {log_pc[1], log_pc[4], log_pc[7], log_pc[10], log_pc[13]}, 40'h00_01_02_03_04);

    // JUMPZ at 0x05 to 0x20, taken and not taken
    fill_plain(); rom[5] = {OP_JUMPZ, 8'h20}; fz_fix = 1;
    do_reset(); run_to(19);
    chk("s2_jumpz_taken", log_addr[19], 8'h20);
    fz_fix = 0;
    do_reset(); run_to(19);
    chk("s2_jumpz_fall", log_addr[19], 8'h06);

    // pc wrap from 0xFF
    fill_plain(); rom[0] = {OP_JUMP, 8'hFF};
    do_reset(); run_to(7);
    chk("s3_at_ff", log_addr[4], 8'hFF);
    chk("s3_wrap", log_addr[7], 8'h00);

    // inbox stall for 10 cycles
    fill_plain(); rom[0] = {OP_INBOX, 8'h10}; iv_on = 13;
    do_reset(); run_to(20);
    cnt = 0;
    for (int i = 1; i <= 20; i++) cnt += log_inr[i];
    chk("s4_inready_cycles", cnt, 11);
    cnt = 0;
    for (int i = 1; i <= 13; i++) cnt += log_ex[i];
    chk("s4_ex_single", cnt, 1);
    chk("s4_ex_at_valid", log_ex[13], 1'b1);
    iv_on = 0;

    // HALT at address 2
    fill_plain(); rom[2] = {OP_HALT, 8'h00};
    do_reset(); run_to(60);
    chk("s5_halted", log_halt[10], 1'b1);
    chk("s5_pc", log_pc[60], 8'h02);
    cnt = 0;
    for (int i = 10; i <= 60; i++) cnt += log_ex[i];
    chk("s5_no_ex", cnt, 0);
    do_reset(); run_to(1);
    chk("s5_restart", log_addr[1], 8'h00);

    // reset during an outbox stall
    fill_plain(); rom[1] = {OP_OUTBOX, 8'h00}; or_on = 100000;
    do_reset(); run_to(8);
    #1 chk("s6_stalled", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("s6_async_drop", {out_valid, exec_en, pc}, {1'b0, 1'b0, 8'h00});
    or_on = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_to(12);
    chk("s6_refetch_ex", {log_ex[1], log_ex[2], log_ex[3]}, 3'b001);

    // randomized programs
    rnd_mode = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_HALT && $urandom_range(0, 31) != 0) op = 4'h4;
        rom[i] = {op, 8'($urandom_range(0, 255))};
      end
      do_reset(); run_to(2500);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
